backing_mem_ctrl: RTL

- Word-addressed backing memory and controller on the memory side of the instruction cache.
- Serves cache line-fill reads with a configurable fixed latency.
- Absorbs dirty-block writebacks into a small write buffer, drains them into the storage array, and forwards buffered data to reads so a fill never returns stale data.

---
 rtl/backing_mem_ctrl_if.sv | 30 +++
 rtl/backing_mem_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/backing_mem_ctrl_if.sv
// Cache-to-backing-memory bus.
// master: cache side (drives read/write requests, receives read data and status).
// slave : backing memory controller.
// Signals: m_ren/m_rd_address (read request), m_wen/m_wr_address/wr_data (write pulse),
//          m_data_in/rd_valid (read response), wr_ready/busy/wr_overflow (status).
interface backing_mem_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADD_WIDTH  = 12
);
    logic                  m_ren;
    logic [ADD_WIDTH-1:0]  m_rd_address;
    logic                  m_wen;
    logic [ADD_WIDTH-1:0]  m_wr_address;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] m_data_in;
    logic                  rd_valid;
    logic                  wr_ready;
    logic                  busy;
    logic                  wr_overflow;

    modport master (
        output m_ren, m_rd_address, m_wen, m_wr_address, wr_data,
        input  m_data_in, rd_valid, wr_ready, busy, wr_overflow
    );

    modport slave (
        input  m_ren, m_rd_address, m_wen, m_wr_address, wr_data,
        output m_data_in, rd_valid, wr_ready, busy, wr_overflow
    );
endinterface

// File: rtl/backing_mem_ctrl.sv
// Word-addressed backing memory behind the instruction cache.
// Serves line-fill reads after a fixed latency, buffers writebacks in a small FIFO,
// drains the FIFO into the array when the array port is free, and forwards
// buffered data to reads so fills never see stale words.
// Ports: clock, reset_n (async active-low), bus (backing_mem_ctrl_if.slave).
module backing_mem_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADD_WIDTH  = 12,
    parameter int unsigned RD_LATENCY = 3,
    parameter int unsigned WB_DEPTH   = 2
) (
    input logic               clock,
    input logic               reset_n,
    backing_mem_ctrl_if.slave bus
);
    localparam int unsigned PTR_W     = $clog2(WB_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned LAT_W     = 4;
    localparam int unsigned MEM_WORDS = 2 ** ADD_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [ADD_WIDTH-1:0]  addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

    state_t                state_q, state_d;
    logic [LAT_W-1:0]      cnt_q, cnt_d;
    logic [ADD_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  wr_ready_q, busy_q;
    logic                  ovf_q, ovf_d;

    wb_entry_t             wb_q  [WB_DEPTH];
    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    logic                  enq, drn;
    logic [ADD_WIDTH-1:0]  lookup_addr;
    logic [DATA_WIDTH-1:0] lookup_data;
    logic [PTR_W-1:0]      scan_idx;

    // Write-buffer enqueue/drain decisions; reads own the array port.
    always_comb begin
        enq      = bus.m_wen && wr_ready_q;
        drn      = (state_q == ST_IDLE) && !bus.m_ren && (count_q != '0);
        wr_ptr_d = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = drn ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(enq) - CNT_W'(drn);
        ovf_d    = ovf_q || (bus.m_wen && !wr_ready_q);
    end

    // Read result as seen in the response cycle: the registered response is
    // captured on the edge entering RESP, so a write enqueued on that same edge
    // is folded in here as the youngest entry.
    always_comb begin
        lookup_addr = (state_q == ST_IDLE) ? bus.m_rd_address : addr_q;
        lookup_data = mem_q[lookup_addr];
        scan_idx    = rd_ptr_q;
        for (int unsigned k = 0; k < WB_DEPTH; k++) begin
            scan_idx = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (wb_q[scan_idx].addr == lookup_addr)) begin
                lookup_data = wb_q[scan_idx].data;
            end
        end
        if (enq && (bus.m_wr_address == lookup_addr)) begin
            lookup_data = bus.wr_data;
        end
    end

    // Read FSM next-state and response outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.m_ren) begin
                    addr_d  = bus.m_rd_address;
                    cnt_d   = LAT_W'(RD_LATENCY - 1);
                    state_d = (RD_LATENCY == 1) ? ST_RESP : ST_READ_WAIT;
                end
            end
            ST_READ_WAIT: begin
                cnt_d = cnt_q - LAT_W'(1);
                if (cnt_q == LAT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        rd_valid_d = (state_d == ST_RESP);
        if (state_d == ST_RESP) begin
            data_d = lookup_data;
        end
    end

    // Control and status registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rd_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wr_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rd_valid_q <= rd_valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wr_ready_q <= (count_d != CNT_W'(WB_DEPTH));
            busy_q     <= (state_d != ST_IDLE) || (count_d != '0);
            ovf_q      <= ovf_d;
        end
    end

    // Buffer and array storage; not reset.
    always_ff @(posedge clock) begin
        if (enq) begin
            wb_q[wr_ptr_q] <= '{addr: bus.m_wr_address, data: bus.wr_data};
        end
        if (drn) begin
            mem_q[wb_q[rd_ptr_q].addr] <= wb_q[rd_ptr_q].data;
        end
    end

    assign bus.m_data_in   = data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.wr_ready    = wr_ready_q;
    assign bus.busy        = busy_q;
    assign bus.wr_overflow = ovf_q;
endmodule
